// File: rtl/l2_pmem_responder.sv
// L2 physical-memory responder: turns held line read/write requests into fixed-length beat bursts.
// Optional burst watchdog enabled by defining PMEM_TIMEOUT_EN.
module l2_pmem_responder #(
  parameter int LINE_BITS      = 128,
  parameter int BEAT_BITS      = 16,
  parameter int ADDR_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_resp,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_err,
  output logic                 dn_cmd_valid,
  input  logic                 dn_cmd_ready,
  output logic                 dn_we,
  output logic [ADDR_BITS-1:0] dn_addr,
  output logic [BEAT_BITS-1:0] dn_wdata,
  output logic                 dn_wvalid,
  input  logic                 dn_wready,
  input  logic [BEAT_BITS-1:0] dn_rdata,
  input  logic                 dn_rvalid
);

  localparam int NBEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WBEAT, S_RBEAT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [LINE_BITS-1:0]   rline_q, rline_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic                   cmd_acc, wbeat_acc, rbeat_acc, tmo_hit;

  assign cmd_acc   = (state_q == S_CMD)   && dn_cmd_ready;
  assign wbeat_acc = (state_q == S_WBEAT) && dn_wready;
  assign rbeat_acc = (state_q == S_RBEAT) && dn_rvalid;

`ifdef PMEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             busy, progress;

  assign busy     = (state_q == S_CMD) || (state_q == S_WBEAT) || (state_q == S_RBEAT);
  assign progress = cmd_acc || wbeat_acc || rbeat_acc;
  assign tmo_hit  = busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  // Counter sits at zero outside a burst, so entry to CMD always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_q <= '0;
    else if (busy && !progress) tmo_q <= tmo_q + 1'b1;
    else                        tmo_q <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    err_d   = err_q;
    rline_d = rline_q;
    wline_d = wline_q;
    case (state_q)
      S_IDLE: begin
        // Write wins when both requests are high.
        if (pmem_write) begin
          addr_d  = pmem_address;
          wline_d = pmem_wdata;
          we_d    = 1'b1;
          err_d   = 1'b0;
          state_d = S_CMD;
        end else if (pmem_read) begin
          addr_d  = pmem_address;
          we_d    = 1'b0;
          err_d   = 1'b0;
          state_d = S_CMD;
`ifdef PMEM_TIMEOUT_EN
          rline_d = '0;
`endif
        end
      end
      S_CMD: begin
        if (cmd_acc) begin
          cnt_d   = '0;
          state_d = we_q ? S_WBEAT : S_RBEAT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WBEAT: begin
        if (wbeat_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_RESP;
        end else if (tmo_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RBEAT: begin
        if (rbeat_acc) begin
          rline_d[cnt_q*BEAT_BITS +: BEAT_BITS] = dn_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_RESP;
        end else if (tmo_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rline_q <= rline_d;
    end
  end

  // Write line is only visible through dn_wdata, which is gated in WBEAT.
  always_ff @(posedge clk) begin
    wline_q <= wline_d;
  end

  assign pmem_resp    = (state_q == S_RESP);
  assign pmem_rdata   = rline_q;
  assign pmem_err     = err_q;
  assign dn_cmd_valid = (state_q == S_CMD);
  assign dn_we        = we_q;
  assign dn_addr      = {addr_q[ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};
  assign dn_wvalid    = (state_q == S_WBEAT);
  assign dn_wdata     = dn_wvalid ? wline_q[cnt_q*BEAT_BITS +: BEAT_BITS] : '0;

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Scoreboard bench for l2_pmem_responder: random L2 requests and downstream handshakes vs a line-level model.
module tb_l2_pmem_responder;
  localparam int LB = 128, BB = 16, AB = 16, NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AB-1:0] pmem_address;
  logic          pmem_read, pmem_write;
  logic [LB-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_err;
  logic          dn_cmd_valid, dn_cmd_ready, dn_we;
  logic [AB-1:0] dn_addr;
  logic [BB-1:0] dn_wdata, dn_rdata;
  logic          dn_wvalid, dn_wready, dn_rvalid;

  always #5 clk = ~clk;

  l2_pmem_responder #(.LINE_BITS(LB), .BEAT_BITS(BB), .ADDR_BITS(AB), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .pmem_err(pmem_err), .dn_cmd_valid(dn_cmd_valid),
    .dn_cmd_ready(dn_cmd_ready), .dn_we(dn_we), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_wvalid(dn_wvalid), .dn_wready(dn_wready), .dn_rdata(dn_rdata), .dn_rvalid(dn_rvalid)
  );

  int total = 0, bad = 0;

  typedef struct packed { logic we; logic [AB-1:0] addr; } cmd_t;
  cmd_t          exp_cmd_q[$];
  logic [LB-1:0] exp_wl_q[$], rl_q[$], exp_rd_q[$];
  logic [LB-1:0] cur_wl = '0, cur_rl = '0, last_rline = '0;
  int            wbeat = 0, rbeat = 0, mode = 1;
  bit            wr_active = 0, rd_active = 0;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic check_reset_outputs();
    check("rst_resp", pmem_resp, 0);
    check("rst_rdata", pmem_rdata, 0);
    check("rst_err", pmem_err, 0);
    check("rst_cmd_valid", dn_cmd_valid, 0);
    check("rst_we", dn_we, 0);
    check("rst_addr", dn_addr, 0);
    check("rst_wdata", dn_wdata, 0);
    check("rst_wvalid", dn_wvalid, 0);
  endtask

  // Monitor: consumes handshakes and responses, compares against the scoreboard.
  initial begin
    cmd_t e;
    logic [LB-1:0] er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dn_rvalid && rd_active) begin
          rbeat++;
          if (rbeat == NB) rd_active = 0;
        end
        if (dn_wvalid) begin
          check("wvalid_in_burst", wr_active, 1);
          if (dn_wready && wr_active) begin
            check("wbeat_data", dn_wdata, cur_wl[wbeat*BB +: BB]);
            wbeat++;
            if (wbeat == NB) wr_active = 0;
          end
        end
        if (dn_cmd_valid && dn_cmd_ready) begin
          if (exp_cmd_q.size() == 0) fail_now("cmd_unexpected");
          else begin
            e = exp_cmd_q.pop_front();
            check("cmd_we", dn_we, e.we);
            check("cmd_addr", dn_addr, e.addr);
            if (e.we) begin cur_wl = exp_wl_q.pop_front(); wbeat = 0; wr_active = 1; end
            else begin cur_rl = rl_q.pop_front(); rbeat = 0; rd_active = 1; end
          end
        end
        if (pmem_resp) begin
          if (exp_rd_q.size() == 0) fail_now("resp_unexpected");
          else begin
            er = exp_rd_q.pop_front();
            check("resp_rdata", pmem_rdata, er);
            check("resp_err", pmem_err, 0);
            check("resp_beats_done", rd_active | wr_active, 0);
          end
        end
      end
    end
  end

  // Downstream memory side: handshake pattern chosen by mode, read beats from the current line.
  initial begin
    dn_cmd_ready = 0; dn_wready = 0; dn_rvalid = 0; dn_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin dn_cmd_ready = 1; dn_wready = 1; dn_rvalid = 1; end
        2: begin dn_cmd_ready = 1; dn_wready = ~dn_wready; dn_rvalid = 1; end
        default: begin
          dn_cmd_ready = ($urandom_range(0, 2) != 0);
          dn_wready    = $urandom_range(0, 1) == 1;
          dn_rvalid    = $urandom_range(0, 1) == 1;
        end
      endcase
      dn_rdata = (rd_active && rbeat < NB) ? cur_rl[rbeat*BB +: BB] : BB'($urandom);
    end
  end

  task automatic start_req(input logic rd, input logic wr, input logic [AB-1:0] a,
                           input logic [LB-1:0] wd, input logic [LB-1:0] rl);
    @(posedge clk);
    #1;
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
    if (wr) begin
      exp_cmd_q.push_back('{we: 1'b1, addr: a & 16'hFFF0});
      exp_wl_q.push_back(wd);
      exp_rd_q.push_back(last_rline);
    end else if (rd) begin
      exp_cmd_q.push_back('{we: 1'b0, addr: a & 16'hFFF0});
      rl_q.push_back(rl);
      exp_rd_q.push_back(rl);
      last_rline = rl;
    end
  endtask

  task automatic wait_resp(input int exp_lat);
    int k = 0;
    bit seen = 0;
    while (!seen && k <= 3000) begin
      @(negedge clk);
      if (pmem_resp) seen = 1;
      else k++;
    end
    if (!seen) fail_now("resp_timeout");
    else if (exp_lat >= 0) check("latency", LB'(k), LB'(exp_lat));
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    pmem_read = 0; pmem_write = 0;
  endtask

  function automatic logic [LB-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LB-1:0] l1;
    int n;
    bit ok;
    rst_n = 0; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Directed read with everything ready: fixed latency and known line.
    mode = 1;
    l1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    start_req(1, 0, 16'h1234, '0, l1);
    wait_resp(10);
    check("read_line_const", pmem_rdata, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    drop_req();

    // Write with toggling wready; read line must survive.
    mode = 2;
    start_req(0, 1, 16'h0040, 128'h0007_0006_0005_0004_0003_0002_0001_0000, '0);
    wait_resp(-1);
    check("write_keeps_rdata", pmem_rdata, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    drop_req();

    // Write-back followed immediately by allocate.
    mode = 0;
    start_req(0, 1, 16'($urandom), rnd_line(), '0);
    wait_resp(-1);
    start_req(1, 0, 16'($urandom), '0, rnd_line());
    wait_resp(-1);
    drop_req();

    // Both requests high: write burst only.
    start_req(1, 1, 16'h5A5A, rnd_line(), '0);
    wait_resp(-1);
    drop_req();

    // Random traffic, with random gaps or back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 2);
      start_req(n != 1, n != 0, 16'($urandom), rnd_line(), rnd_line());
      wait_resp(-1);
      if ($urandom_range(0, 1) == 1) begin
        drop_req();
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    drop_req();

    // Reset in the middle of a read burst.
    mode = 1;
    start_req(1, 0, 16'h7777, '0, rnd_line());
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (rd_active && rbeat == 3) ok = 1;
    end
    if (!ok) fail_now("reset_beat_wait");
    rst_n = 0;
    #1;
    check_reset_outputs();
    pmem_read = 0; pmem_write = 0;
    exp_cmd_q.delete(); exp_wl_q.delete(); rl_q.delete(); exp_rd_q.delete();
    rd_active = 0; wr_active = 0; last_rline = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mode = 0;
    l1 = rnd_line();
    start_req(1, 0, 16'h2468, '0, l1);
    wait_resp(-1);
    check("post_reset_read", pmem_rdata, l1);
    drop_req();

    repeat (6) @(posedge clk);
    #1;
    check("queues_drained", LB'(exp_cmd_q.size() + exp_rd_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
